multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle controller FSM: the successor to the single-cycle decode/control path, for the same MIPS subset
//  (add addi addu sub subu and or sll lw sw beq bne bgtz slt sltu).
//  Sequences FETCH/DECODE/EXEC/MEM/WB with ready-handshaked instruction and data memories, so that
//  datapath registers (PC, IR, regfile) are written only in defined cycles.
//  Adds illegal-opcode skip, a memory-timeout bus error and an optional retire counter.
// PARAMETERS
//  TIMEOUT   16  max cycles a mem request may wait for ready; 0 = never time out
//  CNT_W     32  width of instr_cnt
// PORTS
//  clk         in   1      clock; all state changes on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  op          in   6      IR[31:26]; valid from DECODE onward
//  fun         in   6      IR[5:0]
//  equal       in   1      ALU zero flag (EXEC cycle)
//  sign        in   1      ALU result bit 31 (EXEC cycle)
//  imem_ready  in   1      instruction memory data valid
//  dmem_ready  in   1      data memory access complete
//  imem_req    out  1      instruction fetch request
//  dmem_req    out  1      data memory request
//  dmem_we     out  1      data write (valid with dmem_req)
//  ir_wr       out  1      load IR (1-cycle pulse)
//  pc_wr       out  1      update PC (1-cycle pulse)
//  npc_sel     out  1      1 = branch target, 0 = PC+4 (valid with pc_wr)
//  reg_wr      out  1      regfile write enable
//  reg_dst     out  1      1 = Rd, 0 = Rt
//  ext_op      out  1      sign-extend imm16 (addi/lw/sw)
//  alu_src     out  1      1 = Imm32 operand
//  alu_ctr     out  3      0 and,1 or,2 add,3 slt,4 addu,5 sll,6 sub,7 sltu
//  mem_to_reg  out  1      1 = write-back from memory
//  illegal     out  1      1-cycle pulse when an undecoded op/fun is skipped
//  bus_err     out  1      sticky memory timeout flag
//  instr_cnt   out  CNT_W  retired instruction count
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=FETCH, all outputs 0, timeout counter 0, instr_cnt 0.
//    Asserting reset mid-access drops imem_req/dmem_req immediately, with no partial write.
//  - FETCH: imem_req=1 until imem_ready. In the ready cycle: ir_wr=1, then -> DECODE.
//  - DECODE (1 cycle): classify op/fun. Illegal -> SKIP. Otherwise -> EXEC.
//  - SKIP (1 cycle): illegal=1, pc_wr=1, npc_sel=0 -> FETCH. Not counted as retired.
//  - EXEC (1 cycle): alu_ctr, alu_src, ext_op and reg_dst are driven per instruction and held through MEM/WB.
//    - R-type/addi -> WB. lw/sw -> MEM.
//    - beq/bne/bgtz: pc_wr=1, npc_sel = (beq & equal) | (bne & ~equal) | (bgtz & ~equal & ~sign); branch retires; -> FETCH.
//  - MEM: dmem_req=1 (dmem_we=1 for sw) until dmem_ready.
//    - On ready: sw -> pc_wr=1, retire, -> FETCH; lw -> WB.
//  - WB (1 cycle): reg_wr=1, mem_to_reg=lw, pc_wr=1, npc_sel=0, retire -> FETCH.
//  - Latency with zero wait states: branch 3 cycles, R/addi/sw 4, lw 5. Each wait cycle adds 1.
//  - Timeout: a counter runs while a request is high and ready is low, and clears on ready.
//    When it reaches TIMEOUT: bus_err=1, state -> HALT.
//    HALT: all outputs 0 except bus_err. HALT is left only by reset.
//  - imem_ready in non-FETCH states and dmem_ready outside MEM are ignored.
//  - alu_ctr/ext_op/reg_dst/alu_src are 0 outside EXEC/MEM/WB. pc_wr and reg_wr never assert in the same cycle except in WB.
//  - instr_cnt wraps modulo 2^CNT_W.
// CONFIGURATION
//  - CTRL_PERF_EN defined: instr_cnt increments by 1 on every retiring pc_wr (excludes SKIP).
//  - Not defined: instr_cnt tied to 0 and the counter logic is omitted.
// TESTING
//  - add (op=0, fun=0x20), ready always 1 -> ir_wr @c1, alu_ctr=2 @c3, reg_wr+pc_wr @c4, reg_dst=1.
//  - lw (op=0x23), dmem_ready after 3 waits -> dmem_req high 4 cycles, WB with mem_to_reg=1, total 8 cycles.
//  - bgtz with equal=0, sign=0 -> npc_sel=1 @c3. With sign=1 -> npc_sel=0. bne with equal=1 -> npc_sel=0.
//  - op=0x3F -> illegal pulse, pc_wr=1, npc_sel=0, no reg_wr/dmem_req, instr_cnt unchanged.
//  - TIMEOUT=4, imem_ready held 0 -> bus_err=1 after 4 request cycles, all outputs 0; rst_n pulse -> FETCH.
//  - rst_n low during sw MEM wait -> dmem_req/dmem_we 0 immediately. CTRL_PERF_EN: 10 adds -> instr_cnt=10.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the MIPS subset, with illegal-op skip,
// memory timeout (HALT) and an optional retire counter enabled by CTRL_PERF_EN.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [5:0]       i_op,
  input  logic [5:0]       i_fun,
  input  logic             i_equal,
  input  logic             i_sign,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  output logic             o_imem_req,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic             o_ir_wr,
  output logic             o_pc_wr,
  output logic             o_npc_sel,
  output logic             o_reg_wr,
  output logic             o_reg_dst,
  output logic             o_ext_op,
  output logic             o_alu_src,
  output logic [2:0]       o_alu_ctr,
  output logic             o_mem_to_reg,
  output logic             o_illegal,
  output logic             o_bus_err,
  output logic [CNT_W-1:0] o_instr_cnt
);

  typedef enum logic [2:0] {
    StFetch, StDecode, StSkip, StExec, StMem, StWb, StHalt
  } state_e;

  typedef enum logic [3:0] {
    InAdd, InAddu, InSub, InSubu, InAnd, InOr, InSll, InSlt,
    InSltu, InAddi, InLw, InSw, InBeq, InBne, InBgtz, InIll
  } instr_e;

  localparam int unsigned TmoW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e          r_state, w_state_nxt;
  instr_e          r_instr, w_dec;
  logic [TmoW-1:0] r_tmo;
  logic            r_bus_err;
  logic            w_wait, w_tmo_hit, w_alu_en, w_take;
  logic [2:0]      w_ctr;
  logic            w_src, w_ext, w_rdst;

  always_comb begin
    w_dec = InIll;
    case (i_op)
      6'h00: begin
        case (i_fun)
          6'h20:   w_dec = InAdd;
          6'h21:   w_dec = InAddu;
          6'h22:   w_dec = InSub;
          6'h23:   w_dec = InSubu;
          6'h24:   w_dec = InAnd;
          6'h25:   w_dec = InOr;
          6'h00:   w_dec = InSll;
          6'h2A:   w_dec = InSlt;
          6'h2B:   w_dec = InSltu;
          default: w_dec = InIll;
        endcase
      end
      6'h08:   w_dec = InAddi;
      6'h23:   w_dec = InLw;
      6'h2B:   w_dec = InSw;
      6'h04:   w_dec = InBeq;
      6'h05:   w_dec = InBne;
      6'h07:   w_dec = InBgtz;
      default: w_dec = InIll;
    endcase
  end

  // Datapath controls for the latched instruction; gated to EXEC/MEM/WB below.
  always_comb begin
    w_ctr  = 3'd2;
    w_src  = 1'b0;
    w_ext  = 1'b0;
    w_rdst = 1'b0;
    case (r_instr)
      InAnd:                     begin w_ctr = 3'd0; w_rdst = 1'b1; end
      InOr:                      begin w_ctr = 3'd1; w_rdst = 1'b1; end
      InAdd:                     begin w_ctr = 3'd2; w_rdst = 1'b1; end
      InSlt:                     begin w_ctr = 3'd3; w_rdst = 1'b1; end
      InAddu:                    begin w_ctr = 3'd4; w_rdst = 1'b1; end
      InSll:                     begin w_ctr = 3'd5; w_rdst = 1'b1; end
      InSub, InSubu:             begin w_ctr = 3'd6; w_rdst = 1'b1; end
      InSltu:                    begin w_ctr = 3'd7; w_rdst = 1'b1; end
      InAddi, InLw, InSw:        begin w_ctr = 3'd2; w_src = 1'b1; w_ext = 1'b1; end
      InBeq, InBne, InBgtz:      w_ctr = 3'd6;
      default:                   w_ctr = 3'd2;
    endcase
  end

  assign w_take = ((r_instr == InBeq) & i_equal) | ((r_instr == InBne) & ~i_equal) |
                  ((r_instr == InBgtz) & ~i_equal & ~i_sign);

  assign w_wait    = ((r_state == StFetch) & ~i_imem_ready) | ((r_state == StMem) & ~i_dmem_ready);
  assign w_tmo_hit = (TIMEOUT != 0) && w_wait && (r_tmo == TmoW'(TIMEOUT - 1));

  // Outputs are forced low while reset is asserted so an in-flight access is dropped at once.
  always_comb begin
    w_state_nxt  = r_state;
    w_alu_en     = 1'b0;
    o_imem_req   = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_ir_wr      = 1'b0;
    o_pc_wr      = 1'b0;
    o_npc_sel    = 1'b0;
    o_reg_wr     = 1'b0;
    o_mem_to_reg = 1'b0;
    o_illegal    = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        StFetch: begin
          o_imem_req = 1'b1;
          if (i_imem_ready) begin
            o_ir_wr     = 1'b1;
            w_state_nxt = StDecode;
          end else if (w_tmo_hit) begin
            w_state_nxt = StHalt;
          end
        end
        StDecode: w_state_nxt = (w_dec == InIll) ? StSkip : StExec;
        StSkip: begin
          o_illegal   = 1'b1;
          o_pc_wr     = 1'b1;
          w_state_nxt = StFetch;
        end
        StExec: begin
          w_alu_en = 1'b1;
          if (r_instr inside {InBeq, InBne, InBgtz}) begin
            o_pc_wr     = 1'b1;
            o_npc_sel   = w_take;
            w_state_nxt = StFetch;
          end else if (r_instr inside {InLw, InSw}) begin
            w_state_nxt = StMem;
          end else begin
            w_state_nxt = StWb;
          end
        end
        StMem: begin
          w_alu_en   = 1'b1;
          o_dmem_req = 1'b1;
          o_dmem_we  = (r_instr == InSw);
          if (i_dmem_ready) begin
            o_pc_wr     = (r_instr == InSw);
            w_state_nxt = (r_instr == InSw) ? StFetch : StWb;
          end else if (w_tmo_hit) begin
            w_state_nxt = StHalt;
          end
        end
        StWb: begin
          w_alu_en     = 1'b1;
          o_reg_wr     = 1'b1;
          o_mem_to_reg = (r_instr == InLw);
          o_pc_wr      = 1'b1;
          w_state_nxt  = StFetch;
        end
        StHalt:  w_state_nxt = StHalt;
        default: w_state_nxt = StFetch;
      endcase
    end
  end

  assign o_alu_ctr = w_alu_en ? w_ctr : 3'd0;
  assign o_alu_src = w_alu_en & w_src;
  assign o_ext_op  = w_alu_en & w_ext;
  assign o_reg_dst = w_alu_en & w_rdst;
  assign o_bus_err = r_bus_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StFetch;
      r_instr   <= InIll;
      r_tmo     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StDecode) r_instr <= w_dec;
      if (w_wait && !w_tmo_hit) r_tmo <= r_tmo + TmoW'(1);
      else                      r_tmo <= '0;
      if (w_tmo_hit) r_bus_err <= 1'b1;
    end
  end

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_retire;

  assign w_retire = o_pc_wr & ~o_illegal;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_instr_cnt <= '0;
    else if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
  end

  assign o_instr_cnt = r_instr_cnt;
`else
  assign o_instr_cnt = '0;
`endif

endmodule
